pfb_coeff_stream_tx: RTL and testbench
======================================

// Module: pfb_coeff_stream_tx
// PURPOSE
//  AXI-Stream master that reads a PFB coefficient table from a fixed-latency
//  dual-port RAM and transmits it as one packet. It is the source end of the
//  coefficient reload stream: it produces the frame that the PFB memory
//  controller accepts, for host readback or for loopback reload.
//  It absorbs back-pressure with a small credit-managed skid FIFO.
// PARAMETERS
//  ADDR_W      12    coefficient RAM address width
//  DATA_W      25    coefficient width (signed)
//  NUM_COEFFS  4096  words per frame (2..2**ADDR_W)
//  RD_LAT      3     RAM read latency, from mem_rd_en to mem_dout (cycles)
//  FIFO_DEPTH  4     skid FIFO entries (power of 2, >= RD_LAT+1)
// PORTS
//  clk              in   1       clock
//  sync_reset       in   1       reset, asynchronous, active-high
//  start            in   1       pulse: begin one frame (ignored while busy)
//  busy             out  1       frame in progress
//  done             out  1       1-cycle pulse after the tlast beat is accepted
//  mem_rd_en        out  1       RAM read strobe
//  mem_addr         out  ADDR_W  RAM read address
//  mem_dout         in   DATA_W  RAM data, valid RD_LAT cycles after mem_rd_en
//  m_axis_tvalid    out  1       stream valid
//  m_axis_tdata     out  32      coefficient, sign-extended from DATA_W
//  m_axis_tlast     out  1       high on word NUM_COEFFS-1
//  m_axis_tready    in   1       stream ready
// BEHAVIOUR
//  Reset: all outputs 0. FSM in S_IDLE. FIFO empty. Credit count cleared.
//  FSM: S_IDLE -start-> S_RUN. S_RUN -last read issued-> S_DRAIN.
//       S_DRAIN -tlast beat accepted (tvalid&tready&tlast)-> S_IDLE, and done=1.
//  busy=1 in S_RUN and S_DRAIN. A start pulse while busy has no effect.
//  Reads: in S_RUN, mem_rd_en=1 when inflight+fifo_count < FIFO_DEPTH.
//   mem_addr starts at 0 and increments on each read. Reads stop after
//   address NUM_COEFFS-1. mem_addr returns to 0 in S_IDLE.
//  A delay line of RD_LAT stages tracks rd_en and the last flag. The FIFO is
//   written on the stage output; it never overflows by construction.
//  Stream: tvalid = FIFO not empty; tdata/tlast come from the FIFO head.
//   tdata/tlast stay stable while tvalid&!tready (AXI rule).
//   Simultaneous FIFO push and pop in one cycle: occupancy is unchanged.
//  Throughput: 1 word/cycle when tready stays high. First tvalid appears
//   RD_LAT+1 cycles after start.
//  Reset mid-frame: frame is abandoned, tvalid drops at once, no done pulse.
//   The next start transmits from address 0.
// CONFIGURATION
//  PFB_TX_CHECKSUM_EN defined: adds output checksum[31:0] and checksum_vld.
//   checksum = mod-2^32 sum of the sign-extended tdata beats accepted in the
//   frame. It is cleared on start. checksum_vld rises with done and holds
//   until the next start or reset.
//  Macro not defined: those ports and the adder do not exist; the rest of the
//   behaviour is identical.
// STRUCTURE
//  Shared package pfb_coeff_pkg: state encodings S_IDLE/S_RUN/S_DRAIN,
//   TDATA_W=32, and a sign-extension function for coefficients.
//  Sub-module pfb_coeff_skid_fifo: sync FIFO, DEPTH x (32+1), with count,
//   empty and full outputs.
// TESTING
//  (RAM model: RD_LAT=3, mem[i]=i-2048, NUM_COEFFS=4096, 16-word variant too.)
//  tready=1, start -> 4096 beats, tdata[k]=sext(k-2048), tlast only on k=4095,
//   done 1 cycle after, contiguous beats.
//  Random tready (50%) -> same data order, no loss or duplicate, tdata stable
//   while stalled, no FIFO overflow.
//  tready=0 for 100 cycles after start -> at most FIFO_DEPTH reads issued,
//   then mem_rd_en held 0.
//  start pulsed at beat 10 of a busy frame -> ignored; exactly one frame out.
//  sync_reset at beat 500 -> tvalid=0 at once, no done; next start gives
//   tdata=sext(-2048) first.
//  PFB_TX_CHECKSUM_EN, 16-word frame, mem[i]=i -> checksum=120, checksum_vld
//   with done.

Source files
------------

// File: rtl/pfb_coeff_pkg.sv
// Shared definitions for the PFB coefficient stream source: FSM encodings,
// stream width and coefficient sign extension.
package pfb_coeff_pkg;

    localparam int TDATA_W = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Sign-extend the low 'width' bits of raw to the full stream width.
    function automatic logic [TDATA_W-1:0] sext_coeff(input logic [TDATA_W-1:0] raw,
                                                      input int unsigned        width);
        logic signed [TDATA_W-1:0] w_shl;
        w_shl = $signed(raw << (TDATA_W - width));
        return $unsigned(w_shl >>> (TDATA_W - width));
    endfunction

endpackage

// File: rtl/pfb_coeff_skid_fifo.sv
// Synchronous DEPTH x W FIFO with occupancy count; head is valid whenever not empty.
// Zero-latency read of the head, one-cycle write latency; push and pop in one cycle keep the count.
module pfb_coeff_skid_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 33,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_push_dat,
    input  logic             i_pop,
    output logic [W-1:0]     o_head_dat,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/pfb_coeff_stream_tx.sv
// Reads NUM_COEFFS words from a fixed-latency RAM and sends them as one AXI-Stream packet.
// First tvalid RD_LAT+1 cycles after start; reads are credit-limited so the skid FIFO absorbs stalls. Option: PFB_TX_CHECKSUM_EN.
module pfb_coeff_stream_tx
    import pfb_coeff_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 25,
    parameter int NUM_COEFFS = 4096,
    parameter int RD_LAT     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_dout,
`ifdef PFB_TX_CHECKSUM_EN
    output logic [TDATA_W-1:0] checksum,
    output logic               checksum_vld,
`endif
    output logic               m_axis_tvalid,
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_COEFFS - 1);

    logic [1:0]         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [RD_LAT-1:0]  r_vld_dly;
    logic [RD_LAT-1:0]  r_last_dly;
    logic [CNT_W-1:0]   r_inflight;
    logic               r_done;

    logic [TDATA_W:0]   w_push_dat;
    logic [TDATA_W:0]   w_head;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [CNT_W:0]     w_used;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_rd_en;
    logic               w_last_rd;
    logic               w_start_acc;
    logic               w_frame_end;

    assign w_pop       = !w_empty && m_axis_tready;
    assign w_push      = r_vld_dly[RD_LAT-1];
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_frame_end = (r_state == S_DRAIN) && w_pop && w_head[TDATA_W];

    // Outstanding words (in the RAM pipe or the FIFO) after this cycle's pop;
    // holding it at FIFO_DEPTH keeps the FIFO from overflowing yet allows 1 word/cycle.
    assign w_used    = {1'b0, r_inflight} + {1'b0, w_fifo_count} - {{CNT_W{1'b0}}, w_pop};
    assign w_rd_en   = (r_state == S_RUN) && !w_full && (w_used < (CNT_W+1)'(FIFO_DEPTH));
    assign w_last_rd = w_rd_en && (r_addr == LAST_ADDR);

    assign w_push_dat = {r_last_dly[RD_LAT-1], sext_coeff(TDATA_W'(mem_dout), DATA_W)};

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE:  if (start) r_state <= S_RUN;
                S_RUN:   if (w_last_rd) r_state <= S_DRAIN;
                S_DRAIN: begin
                    if (w_frame_end) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_last_rd)    r_addr <= '0;
            else if (w_rd_en) r_addr <= r_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_vld_dly  <= '0;
            r_last_dly <= '0;
            r_inflight <= '0;
        end else begin
            r_vld_dly[0]  <= w_rd_en;
            r_last_dly[0] <= w_last_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_dly[i]  <= r_vld_dly[i-1];
                r_last_dly[i] <= r_last_dly[i-1];
            end
            r_inflight <= r_inflight + CNT_W'(w_rd_en) - CNT_W'(w_push);
        end
    end

    pfb_coeff_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (TDATA_W + 1)
    ) u_fifo (
        .clk        (clk),
        .rst        (sync_reset),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_fifo_count),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    // Head storage is not reset, so mask it while the FIFO is empty.
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_empty ? '0 : w_head[TDATA_W-1:0];
    assign m_axis_tlast  = !w_empty && w_head[TDATA_W];

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign mem_rd_en = w_rd_en;
    assign mem_addr  = r_addr;

`ifdef PFB_TX_CHECKSUM_EN
    logic [TDATA_W-1:0] r_checksum;
    logic               r_checksum_vld;

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_checksum     <= '0;
            r_checksum_vld <= 1'b0;
        end else if (w_start_acc) begin
            r_checksum     <= '0;
            r_checksum_vld <= 1'b0;
        end else begin
            if (w_pop)       r_checksum     <= r_checksum + m_axis_tdata;
            if (w_frame_end) r_checksum_vld <= 1'b1;
        end
    end

    assign checksum     = r_checksum;
    assign checksum_vld = r_checksum_vld;
`else
    logic w_start_unused;
    assign w_start_unused = w_start_acc;
`endif

endmodule

// File: tb/tb_pfb_coeff_stream_tx.sv
// Bench for pfb_coeff_stream_tx: 4096-word instance (mem[i]=i-2048) and 16-word instance (mem[i]=i).
module tb_pfb_coeff_stream_tx;

    localparam int RD_LAT     = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int DATA_W     = 25;
    localparam int N_A        = 4096;
    localparam int N_B        = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sync_reset;
    logic        tready;
    logic        start_a, start_b;
    logic        sel;

    logic        busy_a, done_a, rd_a, vld_a, last_a;
    logic [11:0] addr_a;
    logic [DATA_W-1:0] dout_a;
    logic [31:0] dat_a;
    logic        busy_b, done_b, rd_b, vld_b, last_b;
    logic [3:0]  addr_b;
    logic [DATA_W-1:0] dout_b;
    logic [31:0] dat_b;
`ifdef PFB_TX_CHECKSUM_EN
    logic [31:0] cs_a, cs_b;
    logic        csv_a, csv_b;
    logic [31:0] cs_at_done, cs_model;
    logic        csv_at_done;
`endif

    pfb_coeff_stream_tx #(.ADDR_W(12), .DATA_W(DATA_W), .NUM_COEFFS(N_A),
                          .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .sync_reset(sync_reset), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_dout(dout_a),
`ifdef PFB_TX_CHECKSUM_EN
        .checksum(cs_a), .checksum_vld(csv_a),
`endif
        .m_axis_tvalid(vld_a), .m_axis_tdata(dat_a), .m_axis_tlast(last_a), .m_axis_tready(tready));

    pfb_coeff_stream_tx #(.ADDR_W(4), .DATA_W(DATA_W), .NUM_COEFFS(N_B),
                          .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut16 (
        .clk(clk), .sync_reset(sync_reset), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_dout(dout_b),
`ifdef PFB_TX_CHECKSUM_EN
        .checksum(cs_b), .checksum_vld(csv_b),
`endif
        .m_axis_tvalid(vld_b), .m_axis_tdata(dat_b), .m_axis_tlast(last_b), .m_axis_tready(tready));

    // RAM models: data appears RD_LAT cycles after the address is presented.
    logic [DATA_W-1:0] pipe_a [RD_LAT];
    logic [DATA_W-1:0] pipe_b [RD_LAT];
    always @(posedge clk) begin
        pipe_a[0] <= DATA_W'(int'(addr_a) - 2048);
        pipe_b[0] <= DATA_W'(addr_b);
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end
    assign dout_a = pipe_a[RD_LAT-1];
    assign dout_b = pipe_b[RD_LAT-1];

    wire        obs_busy = sel ? busy_b : busy_a;
    wire        obs_done = sel ? done_b : done_a;
    wire        obs_rd   = sel ? rd_b   : rd_a;
    wire        obs_vld  = sel ? vld_b  : vld_a;
    wire        obs_last = sel ? last_b : last_a;
    wire [31:0] obs_dat  = sel ? dat_b  : dat_a;
    wire [11:0] obs_addr = sel ? {8'd0, addr_b} : addr_a;

    int n_cmp = 0, n_bad = 0;
    int cyc, cur_n, beat_k, rd_k, data_err, addr_err, stall_err, ovf_err, gap_cnt;
    int done_cnt, first_vld, last_cyc, done_cyc, start_cyc, busy_after, bad_k;
    logic        prev_stall, prev_last;
    logic [31:0] prev_dat;
    logic [31:0] cap_dat  [N_A];
    logic        cap_last [N_A];

    typedef struct {
        int          k;
        logic [31:0] dat;
        logic        last;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic frame_begin(input int n);
        cur_n = n; beat_k = 0; rd_k = 0; data_err = 0; addr_err = 0; stall_err = 0;
        ovf_err = 0; gap_cnt = 0; done_cnt = 0; first_vld = -1; last_cyc = -1;
        done_cyc = -1; busy_after = 0; bad_k = -1; prev_stall = 1'b0;
`ifdef PFB_TX_CHECKSUM_EN
        cs_model = '0; cs_at_done = '0; csv_at_done = 1'b0;
`endif
    endtask

    // One clock cycle: drive inputs just after the edge, observe 2 time units later.
    task automatic step(input logic rdy, input logic st);
        logic [31:0] exp_d;
        @(posedge clk); #1;
        tready  = rdy;
        start_a = st && !sel;
        start_b = st && sel;
        #1;
        if (prev_stall && (!obs_vld || obs_dat != prev_dat || obs_last != prev_last))
            stall_err++;
        prev_stall = obs_vld && !tready;
        prev_dat   = obs_dat;
        prev_last  = obs_last;
        if (obs_rd) begin
            if (int'(obs_addr) != rd_k) addr_err++;
            rd_k++;
        end
        if (obs_vld && first_vld < 0) first_vld = cyc;
        if (obs_vld && tready) begin
            exp_d = sel ? 32'(beat_k) : 32'(beat_k - 2048);
            if (beat_k >= cur_n || obs_dat != exp_d || obs_last != (beat_k == cur_n - 1)) begin
                data_err++;
                if (bad_k < 0) bad_k = beat_k;
            end
            if (beat_k < N_A) begin
                cap_dat[beat_k]  = obs_dat;
                cap_last[beat_k] = obs_last;
            end
`ifdef PFB_TX_CHECKSUM_EN
            cs_model = cs_model + exp_d;
`endif
            if (obs_last) last_cyc = cyc;
            beat_k++;
        end else if (tready && beat_k > 0 && beat_k < cur_n) begin
            gap_cnt++;
        end
        if (rd_k - beat_k > FIFO_DEPTH) ovf_err++;
        if (obs_done) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef PFB_TX_CHECKSUM_EN
            cs_at_done  = sel ? cs_b : cs_a;
            csv_at_done = sel ? csv_b : csv_a;
`endif
        end
        cyc++;
    endtask

    // mode 0: tready always 1, mode 1: random 50%. restart_at >= 0 pulses start at that beat.
    task automatic finish_frame(input int mode, input int restart_at, input int budget);
        logic restarted;
        logic st;
        restarted = 1'b0;
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            st = (restart_at >= 0) && (beat_k == restart_at) && !restarted;
            if (st) restarted = 1'b1;
            step((mode == 1) ? logic'($urandom_range(0, 1)) : 1'b1, st);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            if (obs_busy) busy_after++;
        end
    endtask

    task automatic run_frame(input int mode, input int restart_at, input int budget);
        frame_begin(sel ? N_B : N_A);
        start_cyc = cyc;
        step((mode == 1) ? logic'($urandom_range(0, 1)) : 1'b1, 1'b1);
        finish_frame(mode, restart_at, budget);
    endtask

    task automatic frame_checks(input string tag);
        check($sformatf("%s_beats", tag), beat_k, cur_n);
        check($sformatf("%s_reads", tag), rd_k, cur_n);
        if (data_err != 0) $display("first bad beat in %s: %0d", tag, bad_k);
        check($sformatf("%s_data_errs", tag), data_err, 0);
        check($sformatf("%s_addr_errs", tag), addr_err, 0);
        check($sformatf("%s_stall_errs", tag), stall_err, 0);
        check($sformatf("%s_overflow", tag), ovf_err, 0);
        check($sformatf("%s_done_pulses", tag), done_cnt, 1);
        check($sformatf("%s_done_after_tlast", tag), done_cyc - last_cyc, 1);
        check($sformatf("%s_busy_after", tag), busy_after, 0);
`ifdef PFB_TX_CHECKSUM_EN
        check($sformatf("%s_checksum", tag), cs_at_done, cs_model);
        check($sformatf("%s_checksum_vld", tag), csv_at_done, 1);
`endif
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_at10, vcnt;
        vecs[0] = '{0,    32'hFFFF_F800, 1'b0};
        vecs[1] = '{1,    32'hFFFF_F801, 1'b0};
        vecs[2] = '{2047, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{2048, 32'h0000_0000, 1'b0};
        vecs[4] = '{2049, 32'h0000_0001, 1'b0};
        vecs[5] = '{4094, 32'h0000_07FE, 1'b0};
        vecs[6] = '{4095, 32'h0000_07FF, 1'b1};

        sel = 1'b0; sync_reset = 1'b1; tready = 1'b0; start_a = 1'b0; start_b = 1'b0;
        cyc = 0;
        frame_begin(N_A);
        repeat (3) @(posedge clk);
        #2;
        check("rst_ctrl_a", {busy_a, done_a, rd_a, vld_a, last_a}, 0);
        check("rst_addr_a", addr_a, 0);
        check("rst_tdata_a", dat_a, 0);
        check("rst_ctrl_b", {busy_b, done_b, rd_b, vld_b, last_b, addr_b}, 0);
        @(posedge clk); #1;
        sync_reset = 1'b0;

        // Full frame, tready always high.
        run_frame(0, -1, 5000);
        frame_checks("ready");
        check("ready_gaps", gap_cnt, 0);
        check("ready_first_vld_latency", first_vld - (start_cyc + 1), RD_LAT + 1);
        check("ready_idle_addr", obs_addr, 0);
        foreach (vecs[i])
            check($sformatf("vec_k%0d", vecs[i].k),
                  {cap_last[vecs[i].k], cap_dat[vecs[i].k]}, {vecs[i].last, vecs[i].dat});

        // Random back-pressure.
        run_frame(1, -1, 20000);
        frame_checks("random");

        // tready held low for 100 cycles after start.
        frame_begin(N_A);
        start_cyc = cyc;
        step(1'b0, 1'b1);
        rd_at10 = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0);
            if (i == 9) rd_at10 = rd_k;
        end
        check("stall_reads_le_depth", (rd_k <= FIFO_DEPTH) ? 1 : 0, 1);
        check("stall_reads_issued", rd_k, FIFO_DEPTH);
        check("stall_rd_held_low", rd_k - rd_at10, 0);
        check("stall_beats", beat_k, 0);
        finish_frame(0, -1, 5000);
        frame_checks("stall");

        // start pulsed again at beat 10.
        run_frame(0, 10, 5000);
        frame_checks("restart");

        // Reset at beat 500.
        frame_begin(N_A);
        step(1'b1, 1'b1);
        for (int i = 0; i < 2000 && beat_k < 500; i++) step(1'b1, 1'b0);
        check("rst_mid_reached_500", beat_k, 500);
        @(posedge clk); #1;
        sync_reset = 1'b1;
        #1;
        check("rst_mid_tvalid", vld_a, 0);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_rd_en", rd_a, 0);
        cyc++;
        prev_stall = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        @(posedge clk); #1;
        sync_reset = 1'b0;
        cyc++;
        vcnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0);
            if (obs_vld) vcnt++;
        end
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_no_tvalid", vcnt, 0);
        run_frame(0, -1, 5000);
        frame_checks("after_rst");
        check("after_rst_first_beat", cap_dat[0], 32'hFFFF_F800);

        // 16-word instance (address range fully used).
        sel = 1'b1;
        run_frame(1, -1, 500);
        frame_checks("n16_rand");
`ifdef PFB_TX_CHECKSUM_EN
        check("n16_checksum_120", cs_at_done, 120);
        check("n16_checksum_vld_holds", csv_b, 1);
`endif
        frame_begin(N_B);
        start_cyc = cyc;
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
`ifdef PFB_TX_CHECKSUM_EN
        check("n16_checksum_vld_cleared", csv_b, 0);
`endif
        finish_frame(0, -1, 200);
        frame_checks("n16_ready");
        check("n16_gaps", gap_cnt, 0);
        check("n16_first_vld_latency", first_vld - (start_cyc + 1), RD_LAT + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
